// File: rtl/uart_bus_bridge.sv
// -----------------------------------------------------------------------------
// uart_bus_bridge
//
// Connects a simple req/gnt register bus to a UART core's FIFO interface.
// Each transaction takes three cycles: grant (IDLE), access (ACCESS) and
// response (RESP). The bridge also exposes STATUS/IE/PENDING registers and
// produces a level interrupt from latched UART events.
//
// Register map (word offsets):
//   0 DATA    : write pushes wdata[7:0] to TX FIFO, read pops RX FIFO head
//   1 STATUS  : RO {28'h0, tx_overrun, rx_pending, tx_full, rx_avail}
//   2 IE      : RW bits[1:0] = {tx_space_ie, rx_ie}
//   3 PENDING : bit0 rx became non-empty, bit1 tx FIFO left full (W1C);
//               writing bit2 clears the sticky tx_overrun flag
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i/we_i/addr_i/wdata_i   bus request, held by requester until gnt_o
//   gnt_o                request accepted (combinational, IDLE only)
//   rvalid_o/rdata_o     one-cycle response; rdata_o is 0 outside rvalid_o
//   uart_we_o/uart_tx_wdata_o   TX FIFO push strobe and byte
//   uart_re_o/uart_rx_rdata_i   RX FIFO pop strobe and head byte (FWFT)
//   uart_irq_i           {tx_fifo_full, rx_fifo_nonempty}
//   irq_o                registered level interrupt
// -----------------------------------------------------------------------------
module uart_bus_bridge #(
  parameter logic [31:0] EMPTY_RDATA = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        uart_we_o,
  output logic        uart_re_o,
  output logic [7:0]  uart_tx_wdata_o,
  input  logic [7:0]  uart_rx_rdata_i,
  input  logic [1:0]  uart_irq_i,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_IE      = 2'd2,
    REG_PENDING = 2'd3
  } reg_e;

  state_e      state_q;
  logic        we_q;
  reg_e        addr_q;
  logic [7:0]  wdata_q;     // only the byte and the low control bits are ever used
  logic        wr_ctl2_q;   // wdata bit2, kept separately for the overrun clear
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic [1:0]  ie_q;
  logic [1:0]  pend_q;
  logic [1:0]  irq_prev_q;
  logic        tx_overrun_q;
  logic        irq_q;

  logic        in_access;
  logic        data_hit;
  logic        wr_ie;
  logic        wr_pend;
  logic        ovr_set;
  logic [1:0]  irq_evt;
  logic [1:0]  pend_clr;
  logic [31:0] rd_mux;

  // Upper write-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i[31:8];

  // Grant is only possible from IDLE and never while reset is held, since the
  // state register already sits in IDLE during reset.
  assign gnt_o = rst_ni & req_i & (state_q == IDLE);

  assign in_access = (state_q == ACCESS);
  assign data_hit  = in_access & (addr_q == REG_DATA);

  // FIFO strobes look at the live UART flags during ACCESS so that a FIFO
  // which fills or drains between grant and access is respected.
  assign uart_we_o = data_hit &  we_q & ~uart_irq_i[1];
  assign uart_re_o = data_hit & ~we_q &  uart_irq_i[0];
  assign ovr_set   = data_hit &  we_q &  uart_irq_i[1];

  assign wr_ie    = in_access & we_q & (addr_q == REG_IE);
  assign wr_pend  = in_access & we_q & (addr_q == REG_PENDING);
  assign pend_clr = wr_pend ? wdata_q[1:0] : 2'b00;

  // bit0: rx FIFO became non-empty; bit1: tx FIFO stopped being full.
  assign irq_evt = {irq_prev_q[1] & ~uart_irq_i[1],
                    uart_irq_i[0] & ~irq_prev_q[0]};

  assign uart_tx_wdata_o = wdata_q;
  assign rvalid_o        = rvalid_q;
  assign rdata_o         = rdata_q;
  assign irq_o           = irq_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_mux = 32'h0;
    unique case (addr_q)
      REG_DATA:    rd_mux = uart_irq_i[0] ? {24'h0, uart_rx_rdata_i} : EMPTY_RDATA;
      REG_STATUS:  rd_mux = {28'h0, tx_overrun_q, pend_q[0], uart_irq_i[1], uart_irq_i[0]};
      REG_IE:      rd_mux = {30'h0, ie_q};
      REG_PENDING: rd_mux = {30'h0, pend_q};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= REG_DATA;
      wdata_q   <= 8'h00;
      wr_ctl2_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            we_q      <= we_i;
            addr_q    <= reg_e'(addr_i);
            wdata_q   <= wdata_i[7:0];
            wr_ctl2_q <= wdata_i[2];
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          state_q  <= RESP;
          rvalid_q <= 1'b1;
          rdata_q  <= we_q ? 32'h0 : rd_mux;
        end
        RESP: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
          rdata_q  <= 32'h0;
        end
        default: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
          rdata_q  <= 32'h0;
        end
      endcase
    end
  end

  // Interrupt bookkeeping. A set event in the same cycle as a W1C write wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_prev_q   <= 2'b00;
      pend_q       <= 2'b00;
      ie_q         <= 2'b00;
      tx_overrun_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      irq_prev_q <= uart_irq_i;
      pend_q     <= (pend_q & ~pend_clr) | irq_evt;
      if (ovr_set) begin
        tx_overrun_q <= 1'b1;
      end else if (wr_pend && wr_ctl2_q) begin
        tx_overrun_q <= 1'b0;
      end
      if (wr_ie) begin
        ie_q <= wdata_q[1:0];
      end
      irq_q <= |(ie_q & pend_q);
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// -----------------------------------------------------------------------------
// Testbench for uart_bus_bridge. Inputs change on the falling edge and outputs
// are sampled 1 ns later; a register-level reference model advances on every
// rising edge.
// -----------------------------------------------------------------------------
module tb_uart_bus_bridge;

  localparam logic [31:0] EMPTY = 32'hEEEE_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        we_i;
  logic [1:0]  addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        uart_we_o;
  logic        uart_re_o;
  logic [7:0]  uart_tx_wdata_o;
  logic [7:0]  uart_rx_rdata_i;
  logic [1:0]  uart_irq_i;
  logic        irq_o;

  uart_bus_bridge #(.EMPTY_RDATA(EMPTY)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_i           (req_i),
    .we_i            (we_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .gnt_o           (gnt_o),
    .rvalid_o        (rvalid_o),
    .rdata_o         (rdata_o),
    .uart_we_o       (uart_we_o),
    .uart_re_o       (uart_re_o),
    .uart_tx_wdata_o (uart_tx_wdata_o),
    .uart_rx_rdata_i (uart_rx_rdata_i),
    .uart_irq_i      (uart_irq_i),
    .irq_o           (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural register contents.
  logic [1:0] m_prev, m_pend, m_ie;
  logic       m_ovr, m_irq;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  irq;
    logic [7:0]  rx;
    logic [31:0] exp_rd;
    logic        exp_we;
    logic        exp_re;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 2'b00; m_pend = 2'b00; m_ie = 2'b00; m_ovr = 1'b0; m_irq = 1'b0;
  endtask

  // One rising edge of the register model.
  task automatic model_edge(input bit wr_ie, input bit wr_pend, input bit ovr_set,
                            input logic [31:0] wd);
    logic [1:0] ev;
    ev[0] = uart_irq_i[0] & ~m_prev[0];
    ev[1] = ~uart_irq_i[1] & m_prev[1];
    m_irq = |(m_ie & m_pend);
    if (wr_pend) m_pend = (m_pend & ~wd[1:0]) | ev;
    else         m_pend = m_pend | ev;
    if (ovr_set)              m_ovr = 1'b1;
    else if (wr_pend && wd[2]) m_ovr = 1'b0;
    if (wr_ie) m_ie = wd[1:0];
    m_prev = uart_irq_i;
  endtask

  task automatic cyc(input bit wr_ie, input bit wr_pend, input bit ovr_set,
                     input logic [31:0] wd);
    @(posedge clk_i);
    model_edge(wr_ie, wr_pend, ovr_set, wd);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n, input bit rnd);
    repeat (n) begin
      req_i = 1'b0;
      if (rnd && $urandom_range(3) == 0) uart_irq_i = 2'($urandom);
      #1;
      check("idle_gnt_rvalid", {gnt_o, rvalid_o}, 0);
      check("idle_irq_o", irq_o, m_irq);
      cyc(0, 0, 0, 0);
    end
  endtask

  // Full three-cycle transaction starting at a falling edge with the DUT idle.
  task automatic bus_txn(input logic w, input logic [1:0] a, input logic [31:0] wd,
                         input logic [1:0] i0, input logic [1:0] i1, input logic [1:0] i2,
                         input logic [7:0] rx,
                         output logic [31:0] got_rd, output logic got_we, output logic got_re);
    logic [31:0] exp_rd;
    logic        exp_we, exp_re;
    // grant cycle
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = wd;
    uart_irq_i = i0; uart_rx_rdata_i = rx;
    #1;
    check("gnt", gnt_o, 1);
    check("strobe_in_grant", {uart_we_o, uart_re_o, rvalid_o}, 0);
    check("irq_o_grant", irq_o, m_irq);
    cyc(0, 0, 0, 0);
    // access cycle: scramble bus inputs, the DUT must use what it captured
    req_i = 1'b0; we_i = 1'($urandom); addr_i = 2'($urandom); wdata_i = $urandom;
    uart_irq_i = i1;
    #1;
    exp_we = w && a == 2'd0 && !i1[1];
    exp_re = !w && a == 2'd0 && i1[0];
    if (w) exp_rd = 32'h0;
    else begin
      case (a)
        2'd0:    exp_rd = i1[0] ? {24'h0, rx} : EMPTY;
        2'd1:    exp_rd = {28'h0, m_ovr, m_pend[0], i1[1], i1[0]};
        2'd2:    exp_rd = {30'h0, m_ie};
        default: exp_rd = {30'h0, m_pend};
      endcase
    end
    got_we = uart_we_o;
    got_re = uart_re_o;
    check("uart_we", uart_we_o, exp_we);
    check("uart_re", uart_re_o, exp_re);
    check("access_gnt_rvalid", {gnt_o, rvalid_o}, 0);
    if (exp_we) check("tx_byte", uart_tx_wdata_o, wd[7:0]);
    check("irq_o_access", irq_o, m_irq);
    cyc(w && a == 2'd2, w && a == 2'd3, w && a == 2'd0 && i1[1], wd);
    // response cycle
    uart_irq_i = i2;
    #1;
    got_rd = rdata_o;
    check("rvalid", rvalid_o, 1);
    check("rdata", rdata_o, exp_rd);
    check("resp_strobes", {uart_we_o, uart_re_o, gnt_o}, 0);
    check("irq_o_resp", irq_o, m_irq);
    cyc(0, 0, 0, 0);
  endtask

  function automatic logic [1:0] drift(input logic [1:0] cur);
    return ($urandom_range(3) == 0) ? 2'($urandom) : cur;
  endfunction

  logic [31:0] rd;
  logic        sw, sr;
  logic [8:0]  gmask, wmask, vmask;
  logic [1:0]  i0, i1, i2;

  initial begin
    vecs[0]  = '{1'b1, 2'd0, 32'h0000_0141, 2'b00, 8'h00, 32'h0,        1'b1, 1'b0};
    vecs[1]  = '{1'b1, 2'd0, 32'h0000_0055, 2'b10, 8'h00, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'd1, 32'h0,         2'b10, 8'h00, 32'h0000_000A, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 2'd3, 32'h0000_0004, 2'b10, 8'h00, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'd1, 32'h0,         2'b10, 8'h00, 32'h0000_0002, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 32'h0,         2'b01, 8'hA5, 32'h0000_00A5, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 2'd0, 32'h0,         2'b00, 8'h77, EMPTY,        1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'd3, 32'h0,         2'b00, 8'h00, 32'h0000_0003, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 2'd3, 32'h0000_0003, 2'b00, 8'h00, 32'h0,        1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'd3, 32'h0,         2'b00, 8'h00, 32'h0,        1'b0, 1'b0};
    vecs[10] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 2'b00, 8'h00, 32'h0,        1'b0, 1'b0};
    vecs[11] = '{1'b0, 2'd2, 32'h0,         2'b00, 8'h00, 32'h0000_0003, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 2'd1, 32'h0000_000F, 2'b00, 8'h00, 32'h0,        1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'd1, 32'h0,         2'b00, 8'h00, 32'h0,        1'b0, 1'b0};

    // Reset with a pending request: everything must stay quiet.
    rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 2'd0; wdata_i = 32'h0;
    uart_irq_i = 2'b00; uart_rx_rdata_i = 8'h00;
    model_reset();
    repeat (2) @(negedge clk_i);
    #1;
    check("reset_ctl", {gnt_o, rvalid_o, uart_we_o, uart_re_o, irq_o}, 0);
    check("reset_data", {rdata_o, uart_tx_wdata_o}, 0);
    req_i = 1'b0;
    rst_ni = 1'b1;
    idle(2, 0);

    // Directed register vectors.
    for (int i = 0; i < 14; i++) begin
      bus_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].irq, vecs[i].irq,
              vecs[i].irq, vecs[i].rx, rd, sw, sr);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_strobes", i), {sw, sr}, {vecs[i].exp_we, vecs[i].exp_re});
    end

    // rx interrupt: rising edge -> PENDING[0] -> irq_o, then W1C while input stays high.
    bus_txn(1, 2'd2, 32'h1, 2'b00, 2'b00, 2'b00, 8'h00, rd, sw, sr);
    uart_irq_i = 2'b01;
    idle(1, 0);
    idle(1, 0);
    check("rx_irq_raised", irq_o, 1);
    bus_txn(1, 2'd3, 32'h1, 2'b01, 2'b01, 2'b01, 8'h00, rd, sw, sr);
    check("rx_irq_cleared", irq_o, 0);

    // Set event coinciding with the W1C write keeps the bit set.
    uart_irq_i = 2'b00;
    idle(2, 0);
    bus_txn(1, 2'd3, 32'h1, 2'b00, 2'b01, 2'b01, 8'h00, rd, sw, sr);
    bus_txn(0, 2'd3, 32'h0, 2'b01, 2'b01, 2'b01, 8'h00, rd, sw, sr);
    check("set_beats_clear", rd, 32'h1);

    // tx FIFO leaving full sets PENDING[1].
    uart_irq_i = 2'b11;
    idle(1, 0);
    uart_irq_i = 2'b01;
    idle(1, 0);
    bus_txn(0, 2'd3, 32'h0, 2'b01, 2'b01, 2'b01, 8'h00, rd, sw, sr);
    check("tx_space_pending", rd, 32'h3);
    bus_txn(1, 2'd3, 32'h3, 2'b01, 2'b01, 2'b01, 8'h00, rd, sw, sr);

    // Back-to-back writes with req_i held.
    uart_irq_i = 2'b00;
    req_i = 1'b1; we_i = 1'b1; addr_i = 2'd0; wdata_i = 32'h0000_0077;
    gmask = '0; wmask = '0; vmask = '0;
    for (int k = 0; k < 9; k++) begin
      #1;
      gmask[k] = gnt_o;
      wmask[k] = uart_we_o;
      vmask[k] = rvalid_o;
      cyc(0, 0, 0, 0);
    end
    req_i = 1'b0;
    check("b2b_gnt", gmask, 9'b001_001_001);
    check("b2b_we", wmask, 9'b010_010_010);
    check("b2b_rvalid", vmask, 9'b100_100_100);
    idle(1, 0);

    // Reset during ACCESS of a DATA read aborts the transaction.
    uart_irq_i = 2'b01; uart_rx_rdata_i = 8'h3C;
    req_i = 1'b1; we_i = 1'b0; addr_i = 2'd0;
    #1;
    check("abort_gnt", gnt_o, 1);
    cyc(0, 0, 0, 0);
    check("abort_pre_re", uart_re_o, 1);
    rst_ni = 1'b0;
    #1;
    check("abort_ctl", {gnt_o, rvalid_o, uart_we_o, uart_re_o, irq_o}, 0);
    check("abort_data", {rdata_o, uart_tx_wdata_o}, 0);
    repeat (2) @(negedge clk_i);
    #1;
    check("abort_hold_ctl", {gnt_o, rvalid_o, uart_we_o, uart_re_o, irq_o}, 0);
    req_i = 1'b0;
    rst_ni = 1'b1;
    model_reset();
    idle(3, 0);
    bus_txn(0, 2'd1, 32'h0, 2'b01, 2'b01, 2'b01, 8'h3C, rd, sw, sr);
    check("post_reset_status", rd, 32'h5);

    // Randomized traffic against the model.
    for (int t = 0; t < 200; t++) begin
      i0 = drift(uart_irq_i);
      i1 = drift(i0);
      i2 = drift(i1);
      bus_txn(1'($urandom), 2'($urandom), $urandom, i0, i1, i2, 8'($urandom), rd, sw, sr);
      idle($urandom_range(0, 2), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
